spi_init_sequencer: RTL

Power-up and configuration controller for the RF chip behind the FPGA SPI master. It holds XRESET low for a fixed count and waits a settle interval. It then walks a register-write table, handing one SPI frame at a time to the SPI master over a valid/ready/done handshake. It reports init completion or a handshake timeout, and can re-run the whole sequence on request.

---
 rtl/spi_init_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_init_sequencer.sv
// RF chip power-up sequencer: holds the chip in reset, waits for it to settle,
// then walks the register table one SPI frame at a time with a handshake timeout.
module spi_init_sequencer #(
    parameter int RST_LOW_CYCLES  = 2000,
    parameter int RST_WAIT_CYCLES = 200,
    parameter int NUM_WRITES      = 16,
    parameter int IDX_W           = 4,
    parameter int WORD_W          = 40,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart,
    output logic [IDX_W-1:0]  tbl_addr,
    input  logic [WORD_W-1:0] tbl_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [WORD_W-1:0] cmd_data,
    input  logic              cmd_done,
    output logic              xreset_n,
    output logic              xready,
    output logic              busy,
    output logic              init_done,
    output logic              init_error,
    output logic [IDX_W-1:0]  cur_index
);

    localparam int CNT_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ?
                             RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WRITES - 1);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [TO_W-1:0]   tcnt;
    logic [TO_W-1:0]   tcnt_nx;
    logic [IDX_W-1:0]  addr_nx;
    logic [WORD_W-1:0] data_nx;
    logic              valid_nx;
    logic              xrst_nx;
    logic              xrdy_nx;
    logic              busy_nx;
    logic              done_nx;
    logic              err_nx;
    logic              to_hit;

    // The limit clock is the TIMEOUT_CYCLES-th clock after cmd_valid rose
    assign to_hit    = (tcnt == TO_LAST);
    assign cur_index = tbl_addr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        addr_nx  = tbl_addr;
        data_nx  = cmd_data;
        valid_nx = cmd_valid;
        xrst_nx  = xreset_n;
        xrdy_nx  = xready;
        busy_nx  = busy;
        done_nx  = init_done;
        err_nx   = init_error;
        unique case (state)
            S_RST_LOW: begin
                if (cnt == LOW_LAST) begin
                    state_nx = S_RST_WAIT;
                    cnt_nx   = '0;
                    xrst_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nx = S_FETCH;
                    cnt_nx   = '0;
                    xrdy_nx  = 1'b1;
                    addr_nx  = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_FETCH: begin
                state_nx = S_ISSUE;
                data_nx  = tbl_data;
                valid_nx = 1'b1;
                tcnt_nx  = '0;
            end
            S_ISSUE: begin
                if (to_hit) begin
                    state_nx = S_ERROR;
                    valid_nx = 1'b0;
                    busy_nx  = 1'b0;
                    err_nx   = 1'b1;
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                    if (cmd_ready) begin
                        state_nx = S_WAIT_DONE;
                        valid_nx = 1'b0;
                    end
                end
            end
            S_WAIT_DONE: begin
                // A done on the limit clock still counts as success
                if (cmd_done) begin
                    if (tbl_addr == LAST_IDX) begin
                        state_nx = S_DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_FETCH;
                        addr_nx  = tbl_addr + 1'b1;
                    end
                end else if (to_hit) begin
                    state_nx = S_ERROR;
                    busy_nx  = 1'b0;
                    err_nx   = 1'b1;
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_nx = S_RST_LOW;
                    cnt_nx   = '0;
                    addr_nx  = '0;
                    xrst_nx  = 1'b0;
                    xrdy_nx  = 1'b0;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = S_RST_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RST_LOW;
            cnt        <= '0;
            tcnt       <= '0;
            tbl_addr   <= '0;
            cmd_data   <= '0;
            cmd_valid  <= 1'b0;
            xreset_n   <= 1'b0;
            xready     <= 1'b0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tcnt       <= tcnt_nx;
            tbl_addr   <= addr_nx;
            cmd_data   <= data_nx;
            cmd_valid  <= valid_nx;
            xreset_n   <= xrst_nx;
            xready     <= xrdy_nx;
            busy       <= busy_nx;
            init_done  <= done_nx;
            init_error <= err_nx;
        end
    end

endmodule
